sram_arbiter: RTL and testbench



---
 rtl/atom_sram_pkg.sv | 16 +
 rtl/sram_req_latch.sv | 44 ++++
 rtl/sram_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atom_sram_pkg.sv
// Shared types and constants for the Atom SRAM arbiter.
// The ROM window bounds are used only when SRAM_ARBITER_WPROT_EN is defined.
package atom_sram_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, END} state_t;
  typedef enum logic {GNT_CPU, GNT_DMA} gnt_t;

  localparam logic [17:0] ROM_BASE = 18'h0C000;
  localparam logic [17:0] ROM_LAST = 18'h0FFFF;
  localparam int ACCESS_CYCLES_DEF = 2;

  function automatic logic rom_hit(input logic [17:0] addr);
    return (addr >= ROM_BASE) && (addr <= ROM_LAST);
  endfunction

endpackage

// File: rtl/sram_req_latch.sv
// Holds a CPU request from its single-cycle pulse until the arbiter grants it.
// The eff_* outputs present the request that a grant in this cycle would take.
module sram_req_latch #(
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              rnw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  input  logic              clr,
  output logic              pending,
  output logic              eff_rnw,
  output logic [ADDR_W-1:0] eff_addr,
  output logic [7:0]        eff_wdata
);

  logic              hold_rnw;
  logic [ADDR_W-1:0] hold_addr;
  logic [7:0]        hold_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending    <= 1'b0;
      hold_rnw   <= 1'b1;
      hold_addr  <= '0;
      hold_wdata <= '0;
    end else begin
      if (req) begin
        hold_rnw   <= rnw;
        hold_addr  <= addr;
        hold_wdata <= wdata;
      end
      pending <= (pending | req) & ~clr;
    end
  end

  // A pulse in the same cycle supersedes anything already held (last wins).
  assign eff_rnw   = req ? rnw   : hold_rnw;
  assign eff_addr  = req ? addr  : hold_addr;
  assign eff_wdata = req ? wdata : hold_wdata;

endmodule

// File: rtl/sram_arbiter.sv
// Sequences CPU/DMA accesses to the external async SRAM; CPU wins ties.
// Optional macro SRAM_ARBITER_WPROT_EN suppresses CPU writes into the ROM image.
//
// state  | meaning
// IDLE   | strobes inactive, arbitrate
// SETUP  | address/CS/OE (and write data) driven
// ACCESS | WE low for writes, read data settles; ACCESS_CYCLES clocks
// END    | WE high with CS/addr/data held, ack pulses
module sram_arbiter
  import atom_sram_pkg::*;
#(
  parameter int ADDR_W        = 18,
  parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF,
  parameter int CPU_SLOT      = 25
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_rnw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_rnw,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_wdata,
  output logic [7:0]        dma_rdata,
  output logic              dma_ack,
  output logic              ram_cs_b,
  output logic              ram_oe_b,
  output logic              ram_we_b,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_dout_en,
  input  logic [7:0]        ram_din,
  output logic              busy
);

  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 8 || ACCESS_CYCLES * 2 + 5 >= CPU_SLOT) begin : g_bad_cfg
    $error("sram_arbiter: ACCESS_CYCLES/CPU_SLOT combination is illegal");
  end

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t            state, state_n;
  gnt_t              sel, sel_n, go_sel;
  logic [3:0]        cnt, cnt_n;
  logic              g_rnw, rnw_n, g_mask, mask_n;
  logic              cs_n, oe_n, we_n, den_n, cack_n, dack_n, busy_n;
  logic [ADDR_W-1:0] a_n, go_addr, eff_addr;
  logic [7:0]        dout_n, crd_n, drd_n, go_wdata, eff_wdata;
  logic              go, go_rnw, go_mask, cpu_grant, cpu_pending, eff_rnw;

  sram_req_latch #(.ADDR_W(ADDR_W)) u_req_latch (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (cpu_req),
    .rnw       (cpu_rnw),
    .addr      (cpu_addr),
    .wdata     (cpu_wdata),
    .clr       (cpu_grant),
    .pending   (cpu_pending),
    .eff_rnw   (eff_rnw),
    .eff_addr  (eff_addr),
    .eff_wdata (eff_wdata)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sel_n     = sel;
    rnw_n     = g_rnw;
    mask_n    = g_mask;
    cs_n      = ram_cs_b;
    oe_n      = ram_oe_b;
    we_n      = ram_we_b;
    a_n       = ram_a;
    dout_n    = ram_dout;
    den_n     = ram_dout_en;
    crd_n     = cpu_rdata;
    drd_n     = dma_rdata;
    cack_n    = 1'b0;
    dack_n    = 1'b0;
    cpu_grant = 1'b0;
    go        = 1'b0;
    go_sel    = GNT_CPU;
    go_rnw    = eff_rnw;
    go_addr   = eff_addr;
    go_wdata  = eff_wdata;

    case (state)
      IDLE: begin
        if (cpu_pending || cpu_req) begin
          go        = 1'b1;
          cpu_grant = 1'b1;
        end else if (dma_req) begin
          go       = 1'b1;
          go_sel   = GNT_DMA;
          go_rnw   = dma_rnw;
          go_addr  = dma_addr;
          go_wdata = dma_wdata;
        end
      end
      SETUP: begin
        state_n = ACCESS;
        cnt_n   = CNT_LOAD;
        we_n    = g_rnw | g_mask;
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          state_n = END;
          we_n    = 1'b1;
          if (sel == GNT_CPU) begin
            cack_n = 1'b1;
            if (g_rnw) crd_n = ram_din;
          end else begin
            dack_n = 1'b1;
            if (g_rnw) drd_n = ram_din;
          end
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      END: begin
        state_n = IDLE;
        cs_n    = 1'b1;
        oe_n    = 1'b1;
        den_n   = 1'b0;
      end
      default: state_n = IDLE;
    endcase

`ifdef SRAM_ARBITER_WPROT_EN
    go_mask = (go_sel == GNT_CPU) && !go_rnw && rom_hit(18'(go_addr));
`else
    go_mask = 1'b0;
`endif

    if (go) begin
      state_n = SETUP;
      sel_n   = go_sel;
      rnw_n   = go_rnw;
      mask_n  = go_mask;
      cs_n    = 1'b0;
      oe_n    = !go_rnw;
      we_n    = 1'b1;
      a_n     = go_addr;
      dout_n  = go_wdata;
      den_n   = !go_rnw && !go_mask;
    end

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      sel         <= GNT_CPU;
      g_rnw       <= 1'b1;
      g_mask      <= 1'b0;
      ram_cs_b    <= 1'b1;
      ram_oe_b    <= 1'b1;
      ram_we_b    <= 1'b1;
      ram_a       <= '0;
      ram_dout    <= '0;
      ram_dout_en <= 1'b0;
      cpu_rdata   <= '0;
      dma_rdata   <= '0;
      cpu_ack     <= 1'b0;
      dma_ack     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sel         <= sel_n;
      g_rnw       <= rnw_n;
      g_mask      <= mask_n;
      ram_cs_b    <= cs_n;
      ram_oe_b    <= oe_n;
      ram_we_b    <= we_n;
      ram_a       <= a_n;
      ram_dout    <= dout_n;
      ram_dout_en <= den_n;
      cpu_rdata   <= crd_n;
      dma_rdata   <= drd_n;
      cpu_ack     <= cack_n;
      dma_ack     <= dack_n;
      busy        <= busy_n;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus randomized CPU/DMA traffic
// checked against a shadow memory and the arbitration timing rules.
module tb_sram_arbiter;

  localparam int ACC = 2;
  localparam int LEN = ACC + 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        cpu_req, cpu_rnw, cpu_ack, dma_req, dma_rnw, dma_ack;
  logic [17:0] cpu_addr, dma_addr, ram_a;
  logic [7:0]  cpu_wdata, cpu_rdata, dma_wdata, dma_rdata, ram_dout, ram_din;
  logic        ram_cs_b, ram_oe_b, ram_we_b, ram_dout_en, busy;

  logic [7:0]  mem [0:262143];
  logic [7:0]  shadow [logic [17:0]];
  int          n_checks = 0;
  int          n_pass = 0;
  int          viol_oewe = 0;
  int          viol_den = 0;
  logic        cpu_done;

  sram_arbiter #(.ADDR_W(18), .ACCESS_CYCLES(ACC), .CPU_SLOT(25)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .ram_cs_b(ram_cs_b), .ram_oe_b(ram_oe_b), .ram_we_b(ram_we_b), .ram_a(ram_a),
    .ram_dout(ram_dout), .ram_dout_en(ram_dout_en), .ram_din(ram_din), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [17:0] a);
    if (a == 18'h01234) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ {6'b0, a[17:16]};
  endfunction

  function automatic logic [7:0] expect_rd(input logic [17:0] a);
    if (shadow.exists(a)) return shadow[a];
    return init_val(a);
  endfunction

  assign ram_din = (!ram_cs_b && !ram_oe_b) ? mem[ram_a] : 8'hEE;

  initial begin : sram_model
    for (int i = 0; i < 262144; i++) mem[i] = init_val(18'(i));
    forever begin
      @(posedge clk);
      if (reset_n && !ram_cs_b && !ram_we_b && ram_dout_en) mem[ram_a] = ram_dout;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (!ram_oe_b && !ram_we_b) viol_oewe <= viol_oewe + 1;
      if (ram_dout_en && !ram_oe_b) viol_den <= viol_den + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #5;
    n_checks++; if ({ram_cs_b, ram_oe_b, ram_we_b} !== 3'b111) $display("FAIL reset_strobes got=%b want=111", {ram_cs_b, ram_oe_b, ram_we_b}); else n_pass++;
    n_checks++; if (ram_a !== 18'h0) $display("FAIL reset_ram_a got=%h want=0", ram_a); else n_pass++;
    n_checks++; if ({ram_dout, ram_dout_en} !== 9'h0) $display("FAIL reset_dout got=%h want=0", {ram_dout, ram_dout_en}); else n_pass++;
    n_checks++; if ({cpu_rdata, dma_rdata} !== 16'h0) $display("FAIL reset_rdata got=%h want=0", {cpu_rdata, dma_rdata}); else n_pass++;
    n_checks++; if ({cpu_ack, dma_ack, busy} !== 3'b000) $display("FAIL reset_ack_busy got=%b want=000", {cpu_ack, dma_ack, busy}); else n_pass++;
    reset_n = 1'b1;
    repeat (2) cyc();
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy got=%b want=0", busy); else n_pass++;
  endtask

  task automatic test_cpu_read();
    logic [7:0] oe_m = 0, ack_m = 0, den_m = 0, rd = 0;
    cpu_req = 1; cpu_rnw = 1; cpu_addr = 18'h01234; cpu_wdata = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      cpu_req = 0;
      oe_m[k-1] = !ram_oe_b; ack_m[k-1] = cpu_ack; den_m[k-1] = ram_dout_en;
      if (cpu_ack) rd = cpu_rdata;
    end
    n_checks++; if (oe_m !== 8'((1 << LEN) - 1)) $display("FAIL rd_oe_window got=%b want=%b", oe_m, 8'((1 << LEN) - 1)); else n_pass++;
    n_checks++; if (ack_m !== 8'(1 << (LEN - 1))) $display("FAIL rd_ack_cycle got=%b want=%b", ack_m, 8'(1 << (LEN - 1))); else n_pass++;
    n_checks++; if (den_m !== 8'h0) $display("FAIL rd_dout_en got=%b want=0", den_m); else n_pass++;
    n_checks++; if (rd !== 8'h5A) $display("FAIL rd_data got=%h want=5a", rd); else n_pass++;
    n_checks++; if (cpu_rdata !== 8'h5A) $display("FAIL rd_data_hold got=%h want=5a", cpu_rdata); else n_pass++;
  endtask

  task automatic test_cpu_write();
    logic [7:0] oe_m = 0, ack_m = 0, den_m = 0, we_m = 0;
    int bad_dout = 0;
    cpu_req = 1; cpu_rnw = 0; cpu_addr = 18'h00200; cpu_wdata = 8'hA5;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      cpu_req = 0;
      oe_m[k-1] = !ram_oe_b; ack_m[k-1] = cpu_ack; den_m[k-1] = ram_dout_en; we_m[k-1] = !ram_we_b;
      if (ram_dout_en && ram_dout !== 8'hA5) bad_dout++;
    end
    n_checks++; if (we_m !== 8'(((1 << ACC) - 1) << 1)) $display("FAIL wr_we_window got=%b want=%b", we_m, 8'(((1 << ACC) - 1) << 1)); else n_pass++;
    n_checks++; if (den_m !== 8'((1 << LEN) - 1)) $display("FAIL wr_den_window got=%b want=%b", den_m, 8'((1 << LEN) - 1)); else n_pass++;
    n_checks++; if (oe_m !== 8'h0) $display("FAIL wr_oe got=%b want=0", oe_m); else n_pass++;
    n_checks++; if (ack_m !== 8'(1 << (LEN - 1))) $display("FAIL wr_ack_cycle got=%b want=%b", ack_m, 8'(1 << (LEN - 1))); else n_pass++;
    n_checks++; if (bad_dout !== 0) $display("FAIL wr_dout_value bad_cycles=%0d want=0", bad_dout); else n_pass++;
    n_checks++; if (mem[18'h00200] !== 8'hA5) $display("FAIL wr_mem got=%h want=a5", mem[18'h00200]); else n_pass++;
  endtask

  task automatic test_wprot();
    logic [7:0] we_m = 0, den_m = 0, exp_we, exp_mem;
    logic acked = 0;
`ifdef SRAM_ARBITER_WPROT_EN
    exp_we = 8'h0; exp_mem = init_val(18'h0C010);
`else
    exp_we = 8'(((1 << ACC) - 1) << 1); exp_mem = 8'h77;
`endif
    cpu_req = 1; cpu_rnw = 0; cpu_addr = 18'h0C010; cpu_wdata = 8'h77;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      cpu_req = 0;
      we_m[k-1] = !ram_we_b; den_m[k-1] = ram_dout_en;
      if (cpu_ack) acked = 1;
    end
    n_checks++; if (acked !== 1'b1) $display("FAIL rom_cpu_ack got=%b want=1", acked); else n_pass++;
    n_checks++; if (we_m !== exp_we) $display("FAIL rom_cpu_we got=%b want=%b", we_m, exp_we); else n_pass++;
    n_checks++; if (mem[18'h0C010] !== exp_mem) $display("FAIL rom_cpu_mem got=%h want=%h", mem[18'h0C010], exp_mem); else n_pass++;
    we_m = 0; acked = 0;
    dma_req = 1; dma_rnw = 0; dma_addr = 18'h0C010; dma_wdata = 8'h88;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      we_m[k-1] = !ram_we_b;
      if (dma_ack) begin acked = 1; dma_req = 0; end
    end
    dma_req = 0;
    n_checks++; if (acked !== 1'b1) $display("FAIL rom_dma_ack got=%b want=1", acked); else n_pass++;
    n_checks++; if (we_m !== 8'(((1 << ACC) - 1) << 1)) $display("FAIL rom_dma_we got=%b want=%b", we_m, 8'(((1 << ACC) - 1) << 1)); else n_pass++;
    n_checks++; if (mem[18'h0C010] !== 8'h88) $display("FAIL rom_dma_mem got=%h want=88", mem[18'h0C010]); else n_pass++;
  endtask

  task automatic test_same_cycle();
    int cpu_at = -1, dma_at = -1;
    logic [7:0] crd = 0, drd = 0;
    cpu_req = 1; cpu_rnw = 1; cpu_addr = 18'h20010;
    dma_req = 1; dma_rnw = 1; dma_addr = 18'h30020;
    for (int k = 1; k <= 14; k++) begin
      cyc();
      cpu_req = 0;
      if (cpu_ack) begin cpu_at = k; crd = cpu_rdata; end
      if (dma_ack) begin dma_at = k; drd = dma_rdata; dma_req = 0; end
    end
    dma_req = 0;
    n_checks++; if (cpu_at !== LEN) $display("FAIL tie_cpu_ack_cycle got=%0d want=%0d", cpu_at, LEN); else n_pass++;
    n_checks++; if (dma_at !== 2 * LEN + 1) $display("FAIL tie_dma_ack_cycle got=%0d want=%0d", dma_at, 2 * LEN + 1); else n_pass++;
    n_checks++; if (crd !== init_val(18'h20010)) $display("FAIL tie_cpu_rdata got=%h want=%h", crd, init_val(18'h20010)); else n_pass++;
    n_checks++; if (drd !== init_val(18'h30020)) $display("FAIL tie_dma_rdata got=%h want=%h", drd, init_val(18'h30020)); else n_pass++;
  endtask

  task automatic test_dma_then_cpu();
    int cpu_at = -1, dma_at = -1;
    logic busy_gap = 1'b1;
    logic [7:0] crd = 0;
    dma_req = 1; dma_rnw = 0; dma_addr = 18'h30040; dma_wdata = 8'h3C;
    for (int k = 1; k <= 14; k++) begin
      cyc();
      if (k == 1) begin cpu_req = 1; cpu_rnw = 1; cpu_addr = 18'h20044; end
      else cpu_req = 0;
      if (k == LEN + 1) busy_gap = busy;
      if (cpu_ack) begin cpu_at = k; crd = cpu_rdata; end
      if (dma_ack) begin dma_at = k; dma_req = 0; end
    end
    shadow[18'h30040] = 8'h3C;
    n_checks++; if (dma_at !== LEN) $display("FAIL dcpu_dma_ack_cycle got=%0d want=%0d", dma_at, LEN); else n_pass++;
    n_checks++; if (busy_gap !== 1'b0) $display("FAIL dcpu_idle_gap busy=%b want=0", busy_gap); else n_pass++;
    n_checks++; if (cpu_at !== 2 * LEN + 1) $display("FAIL dcpu_cpu_ack_cycle got=%0d want=%0d", cpu_at, 2 * LEN + 1); else n_pass++;
    n_checks++; if (cpu_at - 1 > 2 * LEN + 1 || cpu_at < 0) $display("FAIL dcpu_latency got=%0d want<=%0d", cpu_at - 1, 2 * LEN + 1); else n_pass++;
    n_checks++; if (crd !== init_val(18'h20044)) $display("FAIL dcpu_rdata got=%h want=%h", crd, init_val(18'h20044)); else n_pass++;
    n_checks++; if (mem[18'h30040] !== 8'h3C) $display("FAIL dcpu_dma_mem got=%h want=3c", mem[18'h30040]); else n_pass++;
  endtask

  task automatic cpu_proc();
    logic [7:0] last_rd = 0, exp_d = 0, data;
    logic have_rd = 0, rnw;
    logic [17:0] addr;
    int gap, lat;
    for (int t = 0; t < 16; t++) begin
      gap = $urandom_range(25, 35);
      lat = 0;
      rnw = 1'($urandom_range(0, 1));
      addr = 18'h20000 | 18'($urandom_range(0, 63));
      data = 8'($urandom);
      if (have_rd) begin
        n_checks++; if (cpu_rdata !== last_rd) $display("FAIL rnd_cpu_rdata_hold got=%h want=%h", cpu_rdata, last_rd); else n_pass++;
      end
      exp_d = expect_rd(addr);
      cpu_req = 1; cpu_rnw = rnw; cpu_addr = addr; cpu_wdata = data;
      do begin cyc(); cpu_req = 0; lat++; end while (!cpu_ack && lat < 12);
      n_checks++;
      if (!cpu_ack || lat < LEN || lat > 2 * LEN + 1) $display("FAIL rnd_cpu_latency got=%0d ack=%b want=%0d..%0d", lat, cpu_ack, LEN, 2 * LEN + 1);
      else n_pass++;
      if (rnw) begin
        n_checks++; if (cpu_rdata !== exp_d) $display("FAIL rnd_cpu_rdata addr=%h got=%h want=%h", addr, cpu_rdata, exp_d); else n_pass++;
        last_rd = exp_d; have_rd = 1;
      end else shadow[addr] = data;
      repeat (gap - lat) cyc();
    end
    cpu_done = 1;
  endtask

  task automatic dma_proc();
    logic [7:0] exp_d, data;
    logic rnw;
    logic [17:0] addr;
    int lat;
    while (!cpu_done) begin
      repeat ($urandom_range(0, 3)) cyc();
      lat = 0;
      rnw = 1'($urandom_range(0, 1));
      addr = 18'h30000 | 18'($urandom_range(0, 63));
      data = 8'($urandom);
      exp_d = expect_rd(addr);
      dma_req = 1; dma_rnw = rnw; dma_addr = addr; dma_wdata = data;
      do begin cyc(); lat++; end while (!dma_ack && lat < 14);
      dma_req = 0;
      n_checks++;
      if (!dma_ack || lat < LEN || lat > 2 * LEN + 2) $display("FAIL rnd_dma_latency got=%0d ack=%b want=%0d..%0d", lat, dma_ack, LEN, 2 * LEN + 2);
      else n_pass++;
      if (rnw) begin
        n_checks++; if (dma_rdata !== exp_d) $display("FAIL rnd_dma_rdata addr=%h got=%h want=%h", addr, dma_rdata, exp_d); else n_pass++;
      end else shadow[addr] = data;
    end
  endtask

  task automatic test_random();
    cpu_done = 0;
    fork
      cpu_proc();
      dma_proc();
    join
    repeat (3) cyc();
  endtask

  task automatic test_reset_mid();
    logic [2:0] strobes;
    logic acked = 0, busy_seen = 0;
    int lat = 0;
    cpu_req = 1; cpu_rnw = 0; cpu_addr = 18'h00300; cpu_wdata = 8'h11;
    cyc(); cpu_req = 0;
    cyc();
    n_checks++; if (ram_we_b !== 1'b0) $display("FAIL rst_pre_we got=%b want=0", ram_we_b); else n_pass++;
    cpu_req = 1; cpu_rnw = 1; cpu_addr = 18'h01234;
    cyc(); cpu_req = 0;
    #2 reset_n = 1'b0;
    #1 strobes = {ram_cs_b, ram_oe_b, ram_we_b};
    n_checks++; if ({strobes, ram_dout_en} !== 4'b1110) $display("FAIL rst_async_strobes got=%b want=1110", {strobes, ram_dout_en}); else n_pass++;
    repeat (3) begin cyc(); if (cpu_ack || dma_ack) acked = 1; end
    #2 reset_n = 1'b1;
    repeat (3) begin cyc(); if (cpu_ack || dma_ack) acked = 1; if (busy) busy_seen = 1; end
    n_checks++; if (acked !== 1'b0) $display("FAIL rst_no_ack got=%b want=0", acked); else n_pass++;
    n_checks++; if (busy_seen !== 1'b0) $display("FAIL rst_pending_lost busy=%b want=0", busy_seen); else n_pass++;
    cpu_req = 1; cpu_rnw = 1; cpu_addr = 18'h01234;
    do begin cyc(); cpu_req = 0; lat++; end while (!cpu_ack && lat < 12);
    n_checks++; if (lat !== LEN || cpu_rdata !== 8'h5A) $display("FAIL rst_recover lat=%0d data=%h want lat=%0d data=5a", lat, cpu_rdata, LEN); else n_pass++;
    repeat (2) cyc();
  endtask

  task automatic test_invariants();
    n_checks++; if (viol_oewe !== 0) $display("FAIL oe_we_overlap cycles=%0d want=0", viol_oewe); else n_pass++;
    n_checks++; if (viol_den !== 0) $display("FAIL dout_en_on_read cycles=%0d want=0", viol_den); else n_pass++;
  endtask

  initial begin
    cpu_req = 0; cpu_rnw = 1; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_rnw = 1; dma_addr = '0; dma_wdata = '0;
    cpu_done = 0;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_wprot();
    test_same_cycle();
    test_dma_then_cpu();
    test_random();
    test_reset_mid();
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
